ahb_resp_mux_dp: RTL and testbench
==================================

Name: ahb_resp_mux_dp

Overview:
- Parametrised slave-to-master response multiplexer for the AHB_Gen interconnect; successor to the purely combinational payload mux.
- Registers the decoder's one-hot address-phase select so routing follows AHB address/data pipelining.
- Provides an integrated default slave: two-cycle ERROR for active transfers that decode to no slave or to multiple slaves, and zero-wait OKAY otherwise.
- Keeps a saturating count of decode errors; sits between the slave-side responses and one master port.

Parameters:
- CHANNEL_NUM, 4, number of slave channels (>=1).
- DATA_W, 32, HRDATA width.
- CNT_W, 8, decode-error counter width.

Ports:
- HCLK  input  1  system clock; all state updates on the rising edge.
- HRESETn  input  1  synchronous, active-low reset.
- hsel_addr  input  CHANNEL_NUM  address-phase slave select from the decoder; expected one-hot or zero.
- htrans  input  2  address-phase HTRANS from the master (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- slv_hrdata  input  CHANNEL_NUM*DATA_W  per-slave HRDATA; channel i occupies bits [i*DATA_W +: DATA_W].
- slv_hreadyout  input  CHANNEL_NUM  per-slave HREADYOUT.
- slv_hresp  input  CHANNEL_NUM  per-slave HRESP (1=ERROR).
- hrdata  output  DATA_W  muxed read data to the master.
- hready  output  1  muxed HREADY; also fed back to slaves and the master.
- hresp  output  1  muxed HRESP.
- dp_sel  output  CHANNEL_NUM  registered data-phase select.
- dec_err_cnt  output  CNT_W  saturating count of default-slave ERROR responses.

Behaviour:
- Address-phase sampling: only on a rising edge where hready==1 (end of the current data phase). When hready==0, dp_sel, FSM state and the counter hold.
- Sampling decision:
  - hsel_addr one-hot: dp_sel <= hsel_addr; FSM -> DS_IDLE. Applies to any htrans; the selected slave handles IDLE/BUSY.
  - hsel_addr zero or multi-hot with htrans[1]==1: dp_sel <= 0; FSM -> DS_ERR1; dec_err_cnt += 1, saturating at 2^CNT_W-1.
  - hsel_addr zero or multi-hot with htrans[1]==0: dp_sel <= 0; FSM -> DS_IDLE.
- FSM states:
  - DS_IDLE: default slave inactive.
  - DS_ERR1: first error cycle.
  - DS_ERR2: second error cycle.
- FSM transitions:
  - DS_ERR1 -> DS_ERR2 unconditionally. Sampling is blocked in this cycle because hready==0.
  - DS_ERR2 drives hready=1, so it performs a normal address-phase sample -> DS_IDLE or DS_ERR1. Back-to-back errors are legal.
- Output mux (combinational from dp_sel/state and slave inputs):
  - dp_sel one-hot (bit i): hrdata=slv_hrdata[i], hready=slv_hreadyout[i], hresp=slv_hresp[i]. Slave wait states and two-cycle slave ERRORs pass through unchanged.
  - dp_sel==0 and DS_IDLE: hrdata=0, hready=1, hresp=0.
  - DS_ERR1: hrdata=0, hready=0, hresp=1.
  - DS_ERR2: hrdata=0, hready=1, hresp=1.
- Latency:
  - Select applies exactly one cycle after its address phase completes.
  - Zero added latency on response paths.
  - The default-slave ERROR takes exactly 2 cycles.
- Reset (HRESETn==0 at a rising edge; has priority over all other updates):
  - dp_sel=0, FSM=DS_IDLE, dec_err_cnt=0.
  - Hence hready=1, hresp=0, hrdata=0 from the first post-reset cycle.
  - Reset mid-wait-state or mid-ERR1 abandons the transfer; no partial response follows.
- CHANNEL_NUM==1: the one-hot check reduces to hsel_addr[0]==1.
- The one-hot check is (hsel_addr!=0) && ((hsel_addr & (hsel_addr-1))==0).

Test Plan:
1. Reset, then idle, all inputs 0 -> hready=1, hresp=0, hrdata=0, dp_sel=0, dec_err_cnt=0.
2. NONSEQ with hsel_addr=4'b0100; slave2 hreadyout low 2 cycles, hrdata=32'hDEADBEEF -> dp_sel=4'b0100 one cycle later; hready 0,0,1; hrdata=DEADBEEF on the completing cycle. A new address presented during the wait is not sampled.
3. NONSEQ with hsel_addr=0 -> next cycle hready=0/hresp=1, then hready=1/hresp=1; dec_err_cnt=1. Repeat with hsel_addr=4'b0110 -> dec_err_cnt=2.
4. IDLE with hsel_addr=0 -> zero-wait OKAY, counter unchanged. BUSY with multi-hot select -> same.
5. Back-to-back: error address sampled in DS_ERR2 followed by a valid slave1 address -> ERR1, ERR2, ERR1, ERR2, then slave1 routed. CNT_W=2 with 5 errors -> counter saturates at 3.
6. HRESETn low during DS_ERR1 and during a slave wait state -> next cycle hready=1, hresp=0, dp_sel=0, dec_err_cnt=0.

Source files
------------

// File: rtl/ahb_resp_mux_dp.sv
// AHB slave-to-master response multiplexer with a registered data-phase select,
// an integrated two-cycle-ERROR default slave and a saturating decode-error counter.
module ahb_resp_mux_dp #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [CHANNEL_NUM-1:0]        hsel_addr,
  input  logic [1:0]                    htrans,
  input  logic [CHANNEL_NUM*DATA_W-1:0] slv_hrdata,
  input  logic [CHANNEL_NUM-1:0]        slv_hreadyout,
  input  logic [CHANNEL_NUM-1:0]        slv_hresp,
  output logic [DATA_W-1:0]             hrdata,
  output logic                          hready,
  output logic                          hresp,
  output logic [CHANNEL_NUM-1:0]        dp_sel,
  output logic [CNT_W-1:0]              dec_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e              state_q, state_d;
  logic [CHANNEL_NUM-1:0] dp_sel_q, dp_sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sel_onehot;

  assign sel_onehot = (hsel_addr != '0) &&
                      ((hsel_addr & (hsel_addr - CHANNEL_NUM'(1))) == '0);

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= DS_IDLE;
      dp_sel_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dp_sel_q <= dp_sel_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: address phase is sampled only when the current data phase completes.
  always_comb begin
    state_d  = state_q;
    dp_sel_d = dp_sel_q;
    cnt_d    = cnt_q;
    case (state_q)
      DS_ERR1: state_d = DS_ERR2;
      default: begin
        if (hready) begin
          if (sel_onehot) begin
            dp_sel_d = hsel_addr;
            state_d  = DS_IDLE;
          end else if (htrans[1]) begin
            dp_sel_d = '0;
            state_d  = DS_ERR1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            dp_sel_d = '0;
            state_d  = DS_IDLE;
          end
        end
      end
    endcase
  end

  // Response mux: selected slave passes through; otherwise the default slave answers.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    case (state_q)
      DS_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      DS_ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: begin
        if (dp_sel_q != '0) begin
          hready = |(dp_sel_q & slv_hreadyout);
          hresp  = |(dp_sel_q & slv_hresp);
          for (int i = 0; i < int'(CHANNEL_NUM); i++) begin
            if (dp_sel_q[i]) hrdata = hrdata | slv_hrdata[i*DATA_W +: DATA_W];
          end
        end
      end
    endcase
  end

  assign dp_sel      = dp_sel_q;
  assign dec_err_cnt = cnt_q;

endmodule

// File: tb/tb_ahb_resp_mux_dp.sv
// Directed scoreboard bench for ahb_resp_mux_dp (4 channels, 32-bit data, 2-bit counter).
module tb_ahb_resp_mux_dp;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [CH-1:0]   hsel_addr;
  logic [1:0]      htrans;
  logic [CH*DW-1:0] slv_hrdata;
  logic [CH-1:0]   slv_hreadyout;
  logic [CH-1:0]   slv_hresp;
  logic [DW-1:0]   hrdata;
  logic            hready;
  logic            hresp;
  logic [CH-1:0]   dp_sel;
  logic [CW-1:0]   dec_err_cnt;

  typedef struct {
    string                   tag;
    logic [1+1+DW+CH+CW-1:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 HCLK = ~HCLK;

  ahb_resp_mux_dp #(.CHANNEL_NUM(CH), .DATA_W(DW), .CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel_addr(hsel_addr), .htrans(htrans),
    .slv_hrdata(slv_hrdata), .slv_hreadyout(slv_hreadyout), .slv_hresp(slv_hresp),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .dp_sel(dp_sel),
    .dec_err_cnt(dec_err_cnt)
  );

  task automatic set_slave(input int ch, input logic rdy, input logic rsp, input logic [DW-1:0] dat);
    slv_hreadyout[ch]         = rdy;
    slv_hresp[ch]             = rsp;
    slv_hrdata[ch*DW +: DW]   = dat;
  endtask

  // One cycle: drive address phase, push expected response, compare, advance to next negedge.
  task automatic step(input string tag, input logic [CH-1:0] sel, input logic [1:0] tr,
                      input logic e_rdy, input logic e_rsp, input logic [DW-1:0] e_dat,
                      input logic [CH-1:0] e_sel, input logic [CW-1:0] e_cnt);
    exp_t e;
    exp_t got;
    logic [1+1+DW+CH+CW-1:0] obs;
    hsel_addr = sel;
    htrans    = tr;
    e.tag = tag;
    e.vec = {e_rdy, e_rsp, e_dat, e_sel, e_cnt};
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    obs = {hready, hresp, hrdata, dp_sel, dec_err_cnt};
    n_cmp++;
    assert (obs === got.vec) else begin
      n_err++;
      $error("FAIL %s: observed rdy/rsp/data/sel/cnt=%h expected %h", got.tag, obs, got.vec);
    end
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0;
    hsel_addr = '0; htrans = IDLE;
    slv_hrdata = '0; slv_hreadyout = '0; slv_hresp = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    step("reset",        4'b0000, IDLE, 1, 0, 32'h0, 4'b0000, 2'd0);
    step("idle",         4'b0000, IDLE, 1, 0, 32'h0, 4'b0000, 2'd0);

    // Slave 2 read with two wait states; a new address during the wait is ignored.
    set_slave(2, 0, 0, 32'hDEADBEEF);
    step("s2_addr",      4'b0100, NSEQ, 1, 0, 32'h0, 4'b0000, 2'd0);
    step("s2_wait1",     4'b0001, NSEQ, 0, 0, 32'hDEADBEEF, 4'b0100, 2'd0);
    step("s2_wait2",     4'b0001, NSEQ, 0, 0, 32'hDEADBEEF, 4'b0100, 2'd0);
    set_slave(2, 1, 0, 32'hDEADBEEF);
    step("s2_done",      4'b0000, IDLE, 1, 0, 32'hDEADBEEF, 4'b0100, 2'd0);

    // Decode errors: no select, then multi-hot sampled in ERR2.
    step("err0_addr",    4'b0000, NSEQ, 1, 0, 32'h0, 4'b0000, 2'd0);
    step("err0_e1",      4'b0000, IDLE, 0, 1, 32'h0, 4'b0000, 2'd1);
    step("err0_e2",      4'b0110, NSEQ, 1, 1, 32'h0, 4'b0000, 2'd1);
    step("errmh_e1",     4'b0000, IDLE, 0, 1, 32'h0, 4'b0000, 2'd2);
    step("errmh_e2",     4'b0000, IDLE, 1, 1, 32'h0, 4'b0000, 2'd2);

    // Inactive transfers to nowhere get zero-wait OKAY.
    step("idle_nosel",   4'b0000, IDLE, 1, 0, 32'h0, 4'b0000, 2'd2);
    step("busy_mh_addr", 4'b1010, BUSY, 1, 0, 32'h0, 4'b0000, 2'd2);
    step("busy_mh_resp", 4'b0000, IDLE, 1, 0, 32'h0, 4'b0000, 2'd2);

    // Back-to-back errors, saturation, then slave 1 routed.
    set_slave(1, 1, 0, 32'h12345678);
    step("b2b_addr",     4'b0000, SEQ,  1, 0, 32'h0, 4'b0000, 2'd2);
    step("b2b_e1a",      4'b0000, IDLE, 0, 1, 32'h0, 4'b0000, 2'd3);
    step("b2b_e2a",      4'b0000, NSEQ, 1, 1, 32'h0, 4'b0000, 2'd3);
    step("b2b_e1b",      4'b0000, IDLE, 0, 1, 32'h0, 4'b0000, 2'd3);
    step("b2b_e2b",      4'b0010, NSEQ, 1, 1, 32'h0, 4'b0000, 2'd3);
    step("s1_data",      4'b0000, IDLE, 1, 0, 32'h12345678, 4'b0010, 2'd3);

    // Slave 1 two-cycle ERROR passes through unchanged.
    step("s1err_addr",   4'b0010, NSEQ, 1, 0, 32'h0, 4'b0000, 2'd3);
    set_slave(1, 0, 1, 32'h12345678);
    step("s1err_c1",     4'b0000, IDLE, 0, 1, 32'h12345678, 4'b0010, 2'd3);
    set_slave(1, 1, 1, 32'h12345678);
    step("s1err_c2",     4'b0000, IDLE, 1, 1, 32'h12345678, 4'b0010, 2'd3);
    set_slave(1, 1, 0, 32'h12345678);

    // Fifth error holds the saturated count; reset during ERR1 abandons it.
    step("sat_addr",     4'b1111, NSEQ, 1, 0, 32'h0, 4'b0000, 2'd3);
    HRESETn = 1'b0;
    step("rst_in_err1",  4'b0000, IDLE, 0, 1, 32'h0, 4'b0000, 2'd3);
    HRESETn = 1'b1;
    step("post_rst_err", 4'b0000, IDLE, 1, 0, 32'h0, 4'b0000, 2'd0);

    // Reset during a slave wait state.
    set_slave(3, 0, 0, 32'hA5A5A5A5);
    step("s3_addr",      4'b1000, NSEQ, 1, 0, 32'h0, 4'b0000, 2'd0);
    HRESETn = 1'b0;
    step("rst_in_wait",  4'b0000, IDLE, 0, 0, 32'hA5A5A5A5, 4'b1000, 2'd0);
    HRESETn = 1'b1;
    step("post_rst_wt",  4'b0000, IDLE, 1, 0, 32'h0, 4'b0000, 2'd0);
    step("final_idle",   4'b0000, IDLE, 1, 0, 32'h0, 4'b0000, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
